// File: rtl/ram_arb2_ctrl.sv
// ram_arb2_ctrl: two-requester arbiter and sequencer for one single-port,
// synchronous-read RAM.
//
// Each requester issues reads and writes over a valid/ready handshake. At most
// one request is granted per cycle; the granted request drives the RAM port.
// Read data comes back the cycle after the grant on a per-port valid/ready
// response channel. If the consumer stalls, the data is captured into a
// per-port hold register.
//
// Configuration macro:
//   RAM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins contention and
//                           no round-robin pointer exists. When undefined
//                           (the default), contention is resolved round-robin.
//
// Ports:
//   clock, resetn                 clock; asynchronous active-low reset
//   req{0,1}_valid/_we/_addr/_wdata/_ready   request channels
//   rsp{0,1}_valid/_rdata/_ready             read response channels
//   ram_addr/_din/_we (out), ram_dout (in)   RAM port
module ram_arb2_ctrl #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_rdata,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_rdata,
  input  logic              rsp1_ready,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {StEmpty, StFirst, StHeld} rsp_st_e;

  rsp_st_e           st_q   [2];
  rsp_st_e           st_d   [2];
  logic [DWIDTH-1:0] hold_q [2];
  logic [DWIDTH-1:0] hold_d [2];

  logic [1:0] elig;
  logic [1:0] gnt;
  logic [1:0] rd_gnt;
  logic [1:0] rsp_vld;
  logic [1:0] rsp_rdy;
  logic [1:0] req_we;

  assign req_we  = {req1_we, req0_we};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_vld[i] = (st_q[i] != StEmpty);
    end
  end

  // A read may only be accepted if its response slot is free or being freed
  // this cycle; writes produce no response, so they are never held back.
  assign elig[0] = req0_valid & (req0_we | ~rsp_vld[0] | rsp0_ready);
  assign elig[1] = req1_valid & (req1_we | ~rsp_vld[1] | rsp1_ready);

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt    = '0;
    gnt[0] = elig[0];
    gnt[1] = elig[1] & ~elig[0];
    // No grant while reset is held so the RAM is never written in reset.
    if (!resetn) gnt = '0;
  end
`else
  logic rr_q;
  logic rr_d;

  always_comb begin
    gnt    = '0;
    gnt[0] = elig[0] & (~elig[1] | ~rr_q);
    gnt[1] = elig[1] & (~elig[0] |  rr_q);
    if (!resetn) gnt = '0;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt[0]) begin
      rr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign rd_gnt     = gnt & ~req_we;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
    end else if (gnt[1]) begin
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
    end
  end

  // Response FSM per port. FIRST forwards ram_dout directly; if the consumer
  // stalls, the data is captured because the RAM output may change next cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      hold_d[i] = hold_q[i];
      unique case (st_q[i])
        StEmpty: begin
          if (rd_gnt[i]) st_d[i] = StFirst;
        end
        StFirst: begin
          if (rsp_rdy[i]) begin
            st_d[i] = rd_gnt[i] ? StFirst : StEmpty;
          end else begin
            hold_d[i] = ram_dout;
            st_d[i]   = StHeld;
          end
        end
        StHeld: begin
          if (rsp_rdy[i]) st_d[i] = rd_gnt[i] ? StFirst : StEmpty;
        end
        default: st_d[i] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= StEmpty;
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  always_comb begin
    rsp0_valid = rsp_vld[0];
    rsp1_valid = rsp_vld[1];
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    if (st_q[0] == StFirst) begin
      rsp0_rdata = ram_dout;
    end else if (st_q[0] == StHeld) begin
      rsp0_rdata = hold_q[0];
    end
    if (st_q[1] == StFirst) begin
      rsp1_rdata = ram_dout;
    end else if (st_q[1] == StHeld) begin
      rsp1_rdata = hold_q[1];
    end
  end

endmodule
